// File: rtl/alu_pkg.sv
// Opcode and FSM state encodings shared by seq_alu and its iterative multiply/divide unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_ADDX = 4'b0011,
        OP_SUBX = 4'b0100,
        OP_MUL  = 4'b0101,
        OP_DIV  = 4'b0110,
        OP_OR   = 4'b0111,
        OP_AND  = 4'b1000,
        OP_XOR  = 4'b1001,
        OP_SLL  = 4'b1010,
        OP_SRL  = 4'b1011,
        OP_SLT  = 4'b1100,
        OP_MFHI = 4'b1101,
        OP_MFLO = 4'b1110,
        OP_NOPX = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle; N iterations.
// The first iteration is applied on the start edge, so the result is ready on the (N-1)th edge after it.
module mdu_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_div,
    input  logic         run,
    input  logic [N-1:0] rda,
    input  logic [N-1:0] rdx,
    output logic         last,
    output logic [N-1:0] hi_nxt,
    output logic [N-1:0] lo_nxt
);

    localparam int CW = $clog2(N);

    // opnd: multiplicand or divisor; upper: partial product or remainder; lower: multiplier or quotient
    logic [N-1:0]  opnd, upper, lower;
    logic          div_mode;
    logic [CW-1:0] cnt;

    logic [N-1:0]  cur_opnd, cur_upper, cur_lower;
    logic          cur_div;
    logic [N:0]    sum, shifted, diff;
    logic [N-1:0]  step_upper, step_lower;

    always_comb begin
        cur_div   = start ? is_div : div_mode;
        cur_upper = start ? '0 : upper;
        cur_opnd  = opnd;
        cur_lower = lower;
        if (start) begin
            cur_opnd  = is_div ? rdx : rda;
            cur_lower = is_div ? rda : rdx;
        end

        sum     = {1'b0, cur_upper} + (cur_lower[0] ? {1'b0, cur_opnd} : {(N+1){1'b0}});
        shifted = {cur_upper, cur_lower[N-1]};
        diff    = shifted - {1'b0, cur_opnd};

        step_upper = sum[N:1];
        step_lower = {sum[0], cur_lower[N-1:1]};
        if (cur_div) begin
            // diff[N] is the borrow: the partial remainder is smaller than the divisor
            if (!diff[N]) begin
                step_upper = diff[N-1:0];
                step_lower = {cur_lower[N-2:0], 1'b1};
            end else begin
                step_upper = shifted[N-1:0];
                step_lower = {cur_lower[N-2:0], 1'b0};
            end
        end
    end

    assign last   = run && (cnt == CW'(N-1));
    assign hi_nxt = step_upper;
    assign lo_nxt = step_lower;

    always_ff @(posedge clk) begin
        if (rst) begin
            opnd     <= '0;
            upper    <= '0;
            lower    <= '0;
            div_mode <= 1'b0;
            cnt      <= '0;
        end else if (start) begin
            opnd     <= cur_opnd;
            upper    <= step_upper;
            lower    <= step_lower;
            div_mode <= is_div;
            cnt      <= CW'(1);
        end else if (run) begin
            upper <= step_upper;
            lower <= step_lower;
            cnt   <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle ops answer the cycle after acceptance, MUL/DIV after N cycles.
// in_ready drops while MUL/DIV iterate; out_valid is a one-cycle pulse with no output backpressure.
module seq_alu
    import alu_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] alu_decode,
    input  logic [N-1:0] rda,
    input  logic [N-1:0] rdx,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic         zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero
);

    localparam int SW = $clog2(N);

    alu_state_t   state;
    alu_op_t      op;
    logic         accept, start, is_div, busy, last, div_zero_q;
    logic [N-1:0] alu_res, hi_nxt, lo_nxt;

    assign op       = alu_op_t'(alu_decode[3:0]);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign is_div   = (op == OP_DIV);
    assign start    = accept && ((op == OP_MUL) || (op == OP_DIV));

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD, OP_ADDX: alu_res = rda + rdx;
            OP_SUB, OP_SUBX: alu_res = rda - rdx;
            OP_OR:           alu_res = rda | rdx;
            OP_AND:          alu_res = rda & rdx;
            OP_XOR:          alu_res = rda ^ rdx;
            OP_SLL:          alu_res = rda << rdx[SW-1:0];
            OP_SRL:          alu_res = rda >> rdx[SW-1:0];
            OP_SLT:          alu_res = {{(N-1){1'b0}}, (rda < rdx)};
            OP_MFHI:         alu_res = hi;
            OP_MFLO:         alu_res = lo;
            default:         alu_res = '0;
        endcase
    end

    mdu_iter #(.N(N)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .is_div (is_div),
        .run    (busy),
        .rda    (rda),
        .rdx    (rdx),
        .last   (last),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b1;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= is_div ? DIV : MUL;
                        div_zero_q <= is_div && (rdx == '0);
                    end else if (accept) begin
                        out_valid   <= 1'b1;
                        result      <= alu_res;
                        zero        <= (alu_res == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    if (last) begin
                        state       <= IDLE;
                        out_valid   <= 1'b1;
                        hi          <= hi_nxt;
                        lo          <= lo_nxt;
                        result      <= lo_nxt;
                        zero        <= (lo_nxt == '0);
                        div_by_zero <= (state == DIV) && div_zero_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
